softmax_dispatcher: RTL and testbench

SOFTMAX_DISPATCHER -- requirements
Module: softmax_dispatcher

---
 rtl/npu_cmd_pkg.sv | 21 ++
 rtl/cmd_fifo.sv | 57 +++++
 rtl/softmax_dispatcher.sv | 140 ++++++++++++++
 tb/tb_softmax_dispatcher.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_cmd_pkg.sv
// Shared types for the NPU command path.
// Dispatcher FSM encoding and the job descriptor.
package npu_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        RESPOND   = 2'd3
    } disp_state_t;

    typedef struct packed {
        logic [31:0] in_ptr;
        logic [31:0] out_ptr;
        logic [31:0] size;
    } job_desc_t;

    localparam int MAX_SIZE_DEFAULT = 256;
    localparam int JOB_W = $bits(job_desc_t);

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous descriptor FIFO, power-of-two depth.
// Head is read combinationally; push and pop may share an edge.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 96
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_MAX);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/softmax_dispatcher.sv
// Queues softmax jobs and sequences them through the unit.
// Head job stays queued until its response is taken.
module softmax_dispatcher
    import npu_cmd_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int MAX_SIZE       = MAX_SIZE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        job_valid,
    output logic        job_ready,
    input  logic [31:0] job_in_ptr,
    input  logic [31:0] job_out_ptr,
    input  logic [31:0] job_size,
    output logic        unit_start,
    output logic [31:0] unit_input_ptr,
    output logic [31:0] unit_output_ptr,
    output logic [31:0] unit_size,
    input  logic        unit_ready,
    input  logic        unit_done,
    input  logic [31:0] unit_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_timeout,
    output logic        rsp_error,
    output logic        busy
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_TERM = CW'(TIMEOUT_CYCLES - 2);

    disp_state_t state, state_n;
    job_desc_t   job_d;
    job_desc_t   head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_pop;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic [CW-1:0] cnt;
    logic        size_ok;
    logic        term;

    assign job_d = '{in_ptr: job_in_ptr, out_ptr: job_out_ptr, size: job_size};

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (JOB_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (job_valid),
        .wr_data (job_d),
        .pop     (fifo_pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign size_ok    = (head.size != '0) && (head.size <= 32'(MAX_SIZE));
    assign term       = (cnt == CNT_TERM);
    assign job_ready  = !fifo_full;
    assign unit_start = (state == ISSUE);
    assign rsp_valid  = (state == RESPOND);
    assign fifo_pop   = (state == RESPOND) && rsp_ready;
    assign busy       = (state != IDLE) || (fifo_count != '0);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    if (!size_ok)        state_n = RESPOND;
                    else if (unit_ready) state_n = ISSUE;
                end
            end
            ISSUE:     state_n = WAIT_DONE;
            WAIT_DONE: if (unit_done || term) state_n = RESPOND;
            RESPOND:   if (rsp_ready) state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    // Descriptor, timeout counter and response payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt             <= '0;
            unit_input_ptr  <= '0;
            unit_output_ptr <= '0;
            unit_size       <= '0;
            rsp_result      <= '0;
            rsp_timeout     <= 1'b0;
            rsp_error       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!fifo_empty && !size_ok) begin
                        rsp_result  <= '0;
                        rsp_timeout <= 1'b0;
                        rsp_error   <= 1'b1;
                    end else if (!fifo_empty && unit_ready) begin
                        unit_input_ptr  <= head.in_ptr;
                        unit_output_ptr <= head.out_ptr;
                        unit_size       <= head.size;
                        rsp_timeout     <= 1'b0;
                        rsp_error       <= 1'b0;
                    end
                end
                ISSUE: cnt <= '0;
                WAIT_DONE: begin
                    if (unit_done) begin
                        rsp_result  <= unit_result;
                        rsp_timeout <= 1'b0;
                        rsp_error   <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                        if (term) begin
                            rsp_result  <= '0;
                            rsp_timeout <= 1'b1;
                            rsp_error   <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_softmax_dispatcher.sv
// Directed bench for softmax_dispatcher.
// Second instance runs with a short timeout.
module tb_softmax_dispatcher;

    typedef struct {
        logic [31:0] ip;
        logic [31:0] op;
        logic [31:0] sz;
        int          dly;
        logic [31:0] res;
        logic        exp_err;
        logic [31:0] exp_res;
    } vec_t;

    typedef struct {
        logic        started;
        logic        valid;
        logic [31:0] in_p;
        logic [31:0] out_p;
        logic [31:0] size;
        logic [31:0] result;
        logic        timeout;
        logic        error;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        job_valid, job_ready;
    logic [31:0] job_in_ptr, job_out_ptr, job_size;
    logic        unit_start;
    logic [31:0] unit_input_ptr, unit_output_ptr, unit_size;
    logic        unit_ready, unit_done;
    logic [31:0] unit_result;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_timeout, rsp_error, busy;

    logic        t_job_valid, t_job_ready;
    logic [31:0] t_job_in_ptr, t_job_out_ptr, t_job_size;
    logic        t_unit_start;
    logic [31:0] t_unit_input_ptr, t_unit_output_ptr, t_unit_size;
    logic        t_unit_ready, t_unit_done;
    logic [31:0] t_unit_result;
    logic        t_rsp_valid, t_rsp_ready;
    logic [31:0] t_rsp_result;
    logic        t_rsp_timeout, t_rsp_error, t_busy;

    softmax_dispatcher #(
        .FIFO_DEPTH(4), .TIMEOUT_CYCLES(4096), .MAX_SIZE(256)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_in_ptr(job_in_ptr), .job_out_ptr(job_out_ptr),
        .job_size(job_size),
        .unit_start(unit_start),
        .unit_input_ptr(unit_input_ptr),
        .unit_output_ptr(unit_output_ptr),
        .unit_size(unit_size),
        .unit_ready(unit_ready), .unit_done(unit_done),
        .unit_result(unit_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_timeout(rsp_timeout),
        .rsp_error(rsp_error), .busy(busy)
    );

    softmax_dispatcher #(
        .FIFO_DEPTH(4), .TIMEOUT_CYCLES(16), .MAX_SIZE(256)
    ) dut_t (
        .clk(clk), .rst_n(rst_n),
        .job_valid(t_job_valid), .job_ready(t_job_ready),
        .job_in_ptr(t_job_in_ptr), .job_out_ptr(t_job_out_ptr),
        .job_size(t_job_size),
        .unit_start(t_unit_start),
        .unit_input_ptr(t_unit_input_ptr),
        .unit_output_ptr(t_unit_output_ptr),
        .unit_size(t_unit_size),
        .unit_ready(t_unit_ready), .unit_done(t_unit_done),
        .unit_result(t_unit_result),
        .rsp_valid(t_rsp_valid), .rsp_ready(t_rsp_ready),
        .rsp_result(t_rsp_result), .rsp_timeout(t_rsp_timeout),
        .rsp_error(t_rsp_error), .busy(t_busy)
    );

    int checks = 0;
    int failures = 0;
    int start_cnt = 0;

    // Count unit_start pulses seen on the main instance.
    always @(posedge clk) begin
        if (unit_start) start_cnt <= start_cnt + 1;
    end

    task automatic chk32(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] ip, input logic [31:0] op,
                        input logic [31:0] sz);
        job_valid = 1'b1;
        job_in_ptr = ip;
        job_out_ptr = op;
        job_size = sz;
        @(negedge clk);
        job_valid = 1'b0;
    endtask

    task automatic serve(input int dly, input logic [31:0] res,
                         output rsp_t r);
        int n;
        n = 0;
        while (!unit_start && !rsp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        r.started = unit_start;
        r.in_p = unit_input_ptr;
        r.out_p = unit_output_ptr;
        r.size = unit_size;
        if (unit_start) begin
            repeat (dly) @(negedge clk);
            unit_done = 1'b1;
            unit_result = res;
            @(negedge clk);
            unit_done = 1'b0;
        end
        n = 0;
        while (!rsp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        r.valid = rsp_valid;
        r.result = rsp_result;
        r.timeout = rsp_timeout;
        r.error = rsp_error;
        if (rsp_valid) begin
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
        end
    endtask

    task automatic t_wait_start(output logic found);
        int n;
        n = 0;
        while (!t_unit_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        found = t_unit_start;
    endtask

    vec_t vecs[6];

    initial begin
        rsp_t r;
        int   s0;
        int   c;
        logic ok;
        logic seen;
        logic legal;

        vecs[0] = '{32'h100, 32'h200, 32'd16, 40, 32'h1, 1'b0, 32'h1};
        vecs[1] = '{32'h110, 32'h210, 32'd0, 3, 32'h9, 1'b1, 32'h0};
        vecs[2] = '{32'h120, 32'h220, 32'd300, 3, 32'h9, 1'b1, 32'h0};
        vecs[3] = '{32'h130, 32'h230, 32'd256, 5, 32'hABCD, 1'b0, 32'hABCD};
        vecs[4] = '{32'h140, 32'h240, 32'd257, 3, 32'h9, 1'b1, 32'h0};
        vecs[5] = '{32'h150, 32'h250, 32'd1, 1, 32'h1234, 1'b0, 32'h1234};

        job_valid = 0; job_in_ptr = 0; job_out_ptr = 0; job_size = 0;
        unit_ready = 1; unit_done = 0; unit_result = 0; rsp_ready = 0;
        t_job_valid = 0; t_job_in_ptr = 0; t_job_out_ptr = 0;
        t_job_size = 0; t_unit_ready = 1; t_unit_done = 0;
        t_unit_result = 0; t_rsp_ready = 0;

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk1("rst_unit_start", unit_start, 1'b0);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk32("rst_rsp_result", rsp_result, 32'h0);
        chk32("rst_unit_in", unit_input_ptr, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk1("post_rst_job_ready", job_ready, 1'b1);
        chk1("post_rst_timeout", rsp_timeout, 1'b0);
        chk1("post_rst_error", rsp_error, 1'b0);

        for (int i = 0; i < 6; i++) begin
            s0 = start_cnt;
            legal = !vecs[i].exp_err;
            chk1($sformatf("v%0d_job_ready", i), job_ready, 1'b1);
            push(vecs[i].ip, vecs[i].op, vecs[i].sz);
            chk1($sformatf("v%0d_start_c1", i), unit_start, 1'b0);
            @(negedge clk);
            chk1($sformatf("v%0d_start_c2", i), unit_start, legal);
            serve(vecs[i].dly, vecs[i].res, r);
            chk1($sformatf("v%0d_rsp_valid", i), r.valid, 1'b1);
            chk32($sformatf("v%0d_result", i), r.result, vecs[i].exp_res);
            chk1($sformatf("v%0d_error", i), r.error, vecs[i].exp_err);
            chk1($sformatf("v%0d_timeout", i), r.timeout, 1'b0);
            if (legal) begin
                chk32($sformatf("v%0d_in_ptr", i), r.in_p, vecs[i].ip);
                chk32($sformatf("v%0d_out_ptr", i), r.out_p, vecs[i].op);
                chk32($sformatf("v%0d_size", i), r.size, vecs[i].sz);
            end
            chk32($sformatf("v%0d_starts", i), start_cnt - s0,
                  legal ? 32'd1 : 32'd0);
            chk1($sformatf("v%0d_rsp_after", i), rsp_valid, 1'b0);
        end

        // Fill the FIFO with the unit stalled; 5th job must wait.
        unit_ready = 1'b0;
        s0 = start_cnt;
        for (int i = 0; i < 4; i++) begin
            chk1($sformatf("fill%0d_ready", i), job_ready, 1'b1);
            push(32'h1000 + i * 16, 32'h2000 + i * 16, 32'd8);
        end
        chk1("full_ready_low", job_ready, 1'b0);
        chk1("full_busy", busy, 1'b1);
        job_valid = 1'b1;
        job_in_ptr = 32'h1040;
        job_out_ptr = 32'h2040;
        job_size = 32'd8;
        ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (job_ready !== 1'b0) ok = 1'b0;
        end
        chk1("full_hold_ready_low", ok, 1'b1);
        chk32("stalled_no_start", start_cnt - s0, 32'd0);
        unit_ready = 1'b1;
        serve(2, 32'h50, r);
        chk32("fifo0_in", r.in_p, 32'h1000);
        chk32("fifo0_res", r.result, 32'h50);
        chk1("fifo_ready_after_pop", job_ready, 1'b1);
        @(negedge clk);
        job_valid = 1'b0;
        for (int i = 1; i < 5; i++) begin
            serve(2, 32'h50 + i, r);
            chk1($sformatf("fifo%0d_valid", i), r.valid, 1'b1);
            chk32($sformatf("fifo%0d_in", i), r.in_p, 32'h1000 + i * 16);
            chk32($sformatf("fifo%0d_res", i), r.result, 32'h50 + i);
        end
        chk1("drain_busy", busy, 1'b0);

        // Response back-pressure with a full queue behind it.
        unit_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(32'h3000 + i * 16, 32'h4000, 32'd4);
        unit_ready = 1'b1;
        c = 0;
        while (!unit_start && c < 50) begin
            @(negedge clk);
            c++;
        end
        chk1("stall_started", unit_start, 1'b1);
        repeat (3) @(negedge clk);
        unit_done = 1'b1;
        unit_result = 32'h77;
        @(negedge clk);
        unit_done = 1'b0;
        chk1("stall_rsp_valid", rsp_valid, 1'b1);
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_result !== 32'h77 ||
                rsp_error !== 1'b0 || rsp_timeout !== 1'b0 ||
                job_ready !== 1'b0 || unit_input_ptr !== 32'h3000)
                ok = 1'b0;
        end
        chk1("stall_stable", ok, 1'b1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk1("stall_popped_ready", job_ready, 1'b1);
        for (int i = 1; i < 4; i++) begin
            serve(1, 32'h80 + i, r);
            chk32($sformatf("stall_drain%0d_in", i), r.in_p,
                  32'h3000 + i * 16);
        end

        // Reset while waiting for the unit.
        push(32'h5000, 32'h6000, 32'd8);
        c = 0;
        while (!unit_start && c < 50) begin
            @(negedge clk);
            c++;
        end
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk1("mid_rst_start", unit_start, 1'b0);
        chk1("mid_rst_busy", busy, 1'b0);
        chk1("mid_rst_valid", rsp_valid, 1'b0);
        chk32("mid_rst_unit_in", unit_input_ptr, 32'h0);
        chk32("mid_rst_unit_out", unit_output_ptr, 32'h0);
        chk32("mid_rst_unit_size", unit_size, 32'h0);
        chk32("mid_rst_result", rsp_result, 32'h0);
        chk1("mid_rst_ready", job_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        s0 = start_cnt;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            unit_done = (k == 3);
            unit_result = 32'hDEAD;
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        unit_done = 1'b0;
        chk1("rst_no_response", seen, 1'b0);
        chk32("rst_no_start", start_cnt - s0, 32'd0);

        // Timeout on the short-timeout instance.
        t_job_valid = 1'b1;
        t_job_in_ptr = 32'h700;
        t_job_out_ptr = 32'h800;
        t_job_size = 32'd32;
        @(negedge clk);
        t_job_valid = 1'b0;
        t_wait_start(ok);
        chk1("to_started", ok, 1'b1);
        c = 0;
        while (!t_rsp_valid && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk32("to_latency", c, 32'd16);
        chk1("to_flag", t_rsp_timeout, 1'b1);
        chk32("to_result", t_rsp_result, 32'h0);
        chk1("to_error", t_rsp_error, 1'b0);
        t_unit_done = 1'b1;
        t_unit_result = 32'hDEAD;
        @(negedge clk);
        t_unit_done = 1'b0;
        chk1("to_late_valid", t_rsp_valid, 1'b1);
        chk1("to_late_flag", t_rsp_timeout, 1'b1);
        chk32("to_late_result", t_rsp_result, 32'h0);
        t_rsp_ready = 1'b1;
        @(negedge clk);
        t_rsp_ready = 1'b0;
        t_unit_done = 1'b1;
        @(negedge clk);
        t_unit_done = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (t_rsp_valid || t_unit_start) seen = 1'b1;
        end
        chk1("to_idle_done_ignored", seen, 1'b0);
        chk1("to_idle_busy", t_busy, 1'b0);

        // Done on the terminal-count cycle beats the timeout.
        t_job_valid = 1'b1;
        t_job_in_ptr = 32'h900;
        @(negedge clk);
        t_job_valid = 1'b0;
        t_wait_start(ok);
        chk1("tie_started", ok, 1'b1);
        repeat (15) @(negedge clk);
        t_unit_done = 1'b1;
        t_unit_result = 32'hBEEF;
        @(negedge clk);
        t_unit_done = 1'b0;
        chk1("tie_valid", t_rsp_valid, 1'b1);
        chk1("tie_timeout", t_rsp_timeout, 1'b0);
        chk32("tie_result", t_rsp_result, 32'hBEEF);
        t_rsp_ready = 1'b1;
        @(negedge clk);
        t_rsp_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
